// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: FSM encoding,
// anode idle pattern, requester ids and the round-robin pick helper.
package display_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;
    localparam logic [1:0] ST_SHOW  = 2'd3;

    localparam logic [3:0] AN_OFF = 4'b1111;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // On a tie the requester that did not win last time gets the frame.
    function automatic logic rr_pick(input logic req_a, input logic req_b,
                                     input logic last_win);
        logic win;
        if (req_a && req_b) begin
            win = ~last_win;
        end else if (req_b) begin
            win = REQ_B;
        end else begin
            win = REQ_A;
        end
        return win;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_hex_to_7seg.sv
// Hex nibble to seven-segment decoder, active-high segments ordered {g,f,e,d,c,b,a}.
module hex_to_7seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        case (hex_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Round-robin arbitrated, frame-snapshotted 4-digit seven-segment scanner
// with a blanking gap before every digit.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        grant_a,
    output logic        grant_b,
    output logic        frame_st,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [1:0]  state_dbg
);

    // Sized for the longer of the two reload values so neither can wrap.
    localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      frame_q, frame_d;
    logic             grant_a_q, grant_a_d;
    logic             grant_b_q, grant_b_d;
    logic             last_win_q, last_win_d;
    logic             frame_st_q, frame_st_d;
    logic [3:0]       an_q, an_d;
    logic             win;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        grant_a_d  = grant_a_q;
        grant_b_d  = grant_b_q;
        last_win_d = last_win_q;
        frame_st_d = 1'b0;
        win        = rr_pick(req_a, req_b, last_win_q);

        if (!en) begin
            state_d   = ST_IDLE;
            idx_d     = 2'd0;
            grant_a_d = 1'b0;
            grant_b_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARB;
                ST_ARB: begin
                    grant_a_d  = (req_a || req_b) && (win == REQ_A);
                    grant_b_d  = (req_a || req_b) && (win == REQ_B);
                    if (req_a || req_b) begin
                        frame_d    = (win == REQ_A) ? data_a : data_b;
                        last_win_d = win;
                    end
                    idx_d      = 2'd0;
                    frame_st_d = 1'b1;
                    cnt_d      = BLANK_LOAD;
                    state_d    = ST_BLANK;
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        cnt_d   = DIV_LOAD;
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (idx_q != 2'd3) begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = BLANK_LOAD;
                        state_d = ST_BLANK;
                    end else begin
                        state_d = ST_ARB;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Anodes are registered from the next state so they never glitch.
        an_d = (state_d == ST_SHOW) ? ~(4'b0001 << idx_d) : AN_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            frame_q    <= 16'h0000;
            grant_a_q  <= 1'b0;
            grant_b_q  <= 1'b0;
            last_win_q <= REQ_B;
            frame_st_q <= 1'b0;
            an_q       <= AN_OFF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            grant_a_q  <= grant_a_d;
            grant_b_q  <= grant_b_d;
            last_win_q <= last_win_d;
            frame_st_q <= frame_st_d;
            an_q       <= an_d;
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .hex_i (frame_q[{idx_q, 2'b00} +: 4]),
        .seg_o (seg)
    );

    assign grant_a   = grant_a_q;
    assign grant_b   = grant_b_q;
    assign frame_st  = frame_st_q;
    assign an        = an_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a short scan (4 lit + 2 dark
// cycles per digit, 25-cycle frames) and hand-computed expectations.
module tb_display_scan_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 2;

    logic        clk = 1'b0;
    logic        rst_n, en, req_a, req_b;
    logic [15:0] data_a, data_b;
    logic        grant_a, grant_b, frame_st;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .grant_a   (grant_a),
        .grant_b   (grant_b),
        .frame_st  (frame_st),
        .an        (an),
        .seg       (seg),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Entered on the first BLANK cycle of a frame, returns on its closing ARB cycle.
    // At the first lit cycle of digit 1 the inputs are switched to the mid_* values.
    task automatic check_frame(input logic [15:0] exp_data, input logic ga, input logic gb,
                               input logic [15:0] mid_data_a, input logic mid_req_a,
                               input logic mid_req_b);
        logic [3:0] exp_an;
        logic [3:0] nib;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < BLANK_CYC; c++) begin
                check("blank_an", an, 4'hF);
                check("blank_fst", frame_st, (d == 0 && c == 0));
                step();
            end
            check("grant_a", grant_a, ga);
            check("grant_b", grant_b, gb);
            exp_an = ~(4'b0001 << d);
            nib    = exp_data[d*4 +: 4];
            for (int c = 0; c < CLK_DIV; c++) begin
                check("show_an", an, exp_an);
                check("show_seg", seg, seg_of(nib));
                check("show_fst", frame_st, 1'b0);
                if (d == 1 && c == 0) begin
                    data_a = mid_data_a;
                    req_a  = mid_req_a;
                    req_b  = mid_req_b;
                end
                step();
            end
        end
        check("arb_state", state_dbg, 2'd1);
        check("arb_an", an, 4'hF);
        check("arb_fst", frame_st, 1'b0);
        check("arb_grant_a", grant_a, ga);
        check("arb_grant_b", grant_b, gb);
    endtask

    task automatic wait_lit();
        for (int i = 0; i < 20; i++) begin
            if (an != 4'hF) break;
            step();
        end
        check("lit_timeout", (an != 4'hF), 1'b1);
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 16'h0000;
        data_b = 16'h0000;
        #12;
        check("rst_an", an, 4'hF);
        check("rst_grant_a", grant_a, 1'b0);
        check("rst_grant_b", grant_b, 1'b0);
        check("rst_fst", frame_st, 1'b0);
        check("rst_state", state_dbg, 2'd0);

        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        en     = 1'b1;
        req_a  = 1'b1;
        data_a = 16'h1234;
        data_b = 16'hBEEF;
        step();
        check("start_arb", state_dbg, 2'd1);
        check("start_fst_early", frame_st, 1'b0);
        step();
        check("start_fst", frame_st, 1'b1);

        // A alone; B starts requesting mid-frame and takes the next frame
        check_frame(16'h1234, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b1);
        step();
        check_frame(16'hBEEF, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b1);
        step();
        // data_a changes mid-frame but the snapshot holds
        check_frame(16'h1234, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1);
        step();
        check_frame(16'hBEEF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1);
        step();
        check_frame(16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        step();
        // nobody requesting: grants drop and the last frame keeps scanning
        check_frame(16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
        step();
        check_frame(16'hBEEF, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
        step();

        wait_lit();
        en = 1'b0;
        step();
        check("dis_an", an, 4'hF);
        check("dis_grant_a", grant_a, 1'b0);
        check("dis_grant_b", grant_b, 1'b0);
        check("dis_state", state_dbg, 2'd0);
        step();
        check("dis_hold_state", state_dbg, 2'd0);
        en = 1'b1;
        step();
        check("reen_arb", state_dbg, 2'd1);
        step();
        check("reen_fst", frame_st, 1'b1);
        check_frame(16'hBEEF, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
        step();

        wait_lit();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_an", an, 4'hF);
        check("async_grant_a", grant_a, 1'b0);
        check("async_grant_b", grant_b, 1'b0);
        check("async_state", state_dbg, 2'd0);
        @(posedge clk);
        #1;
        req_a = 1'b1;
        req_b = 1'b1;
        rst_n = 1'b1;
        step();
        check("rerst_arb", state_dbg, 2'd1);
        step();
        check("rerst_fst", frame_st, 1'b1);
        // tie right after reset goes to A
        check_frame(16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
